// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: field widths, per-round shift tables, FSM states.
// Pure declarations; no logic, no latency.
package des_pkg;
  localparam int CD_W    = 28;
  localparam int KEY56_W = 56;
  localparam int RK_W    = 48;
  localparam int CNT_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_t;

  // Decrypt undoes the encrypt shifts in reverse order; round 0 reuses C16/D16 == C0/D0.
  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
endpackage

// File: rtl/des_cd_rotator.sv
// Rotates the 28-bit C and D halves independently by 0..2 places, left or right.
// Purely combinational, zero latency, no flow control.
module cd_rotator
  import des_pkg::*;
(
  input  logic [CD_W-1:0] i_c,
  input  logic [CD_W-1:0] i_d,
  input  logic [1:0]      i_shift,
  input  logic            i_right,
  output logic [CD_W-1:0] o_c,
  output logic [CD_W-1:0] o_d
);
  function automatic logic [CD_W-1:0] rot28(input logic [CD_W-1:0] x,
                                            input logic [1:0] s,
                                            input logic right);
    logic [CD_W-1:0] r;
    r = x;
    case (s)
      2'd1:    r = right ? {x[0], x[CD_W-1:1]}   : {x[CD_W-2:0], x[CD_W-1]};
      2'd2:    r = right ? {x[1:0], x[CD_W-1:2]} : {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
      default: r = x;
    endcase
    return r;
  endfunction

  assign o_c = rot28(i_c, i_shift, i_right);
  assign o_d = rot28(i_d, i_shift, i_right);
endmodule

// File: rtl/p_box_56_48.sv
// DES PC2 permutation: 56-bit {C,D} in, 48-bit round key out, bit 1 = MSB.
// Purely combinational, zero latency, no flow control.
module p_box_56_48
  import des_pkg::*;
(
  input  logic [KEY56_W-1:0] i_dat,
  output logic [RK_W-1:0]    o_dat
);
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < RK_W; i++) begin : g_bit
    assign o_dat[RK_W-1-i] = i_dat[KEY56_W-PC2[i]];
  end

  // PC2 discards input positions 9, 18, 22, 25, 35, 38, 43 and 54.
  logic w_unused;
  assign w_unused = ^{i_dat[47], i_dat[38], i_dat[34], i_dat[31],
                      i_dat[21], i_dat[18], i_dat[13], i_dat[2]};
endmodule

// File: rtl/des_key_sched_iter.sv
// Iterative DES key schedule: streams NUM_ROUNDS round keys per loaded key, first key 1 cycle after load.
// Round keys hold while rk_ready_i is low; abort_i drops the schedule; optional zero-bubble reload on last beat.
module des_key_sched_iter
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS   = 16,
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               key_valid_i,
  output logic               key_ready_o,
  input  logic [KEY56_W-1:0] key_i,
  input  logic               decrypt_i,
  input  logic               abort_i,
  output logic               rk_valid_o,
  input  logic               rk_ready_i,
  output logic [RK_W-1:0]    rk_o,
  output logic [CNT_W-1:0]   rk_idx_o,
  output logic               rk_last_o,
  output logic               busy_o
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CD_W-1:0]  r_c;
  logic [CD_W-1:0]  r_d;
  logic             r_mode;

  logic             w_gen;
  logic             w_last;
  logic             w_fire;
  logic             w_load;
  logic [1:0]       w_shift;
  logic [CD_W-1:0]  w_c_rot;
  logic [CD_W-1:0]  w_d_rot;
  logic [RK_W-1:0]  w_pc2;

  assign w_gen   = (r_state == ST_GEN);
  assign w_last  = w_gen && (r_cnt == CNT_W'(NUM_ROUNDS - 1));
  assign w_fire  = w_gen && rk_ready_i && !abort_i;
  assign w_shift = r_mode ? DEC_SHIFT[r_cnt] : ENC_SHIFT[r_cnt];

  // A reload on the last beat is only offered while that beat is actually handshaking.
  assign key_ready_o = !w_gen || (BACK_TO_BACK && w_last && rk_ready_i && !abort_i);
  assign w_load      = key_valid_i && key_ready_o;

  cd_rotator u_rot (
    .i_c     (r_c),
    .i_d     (r_d),
    .i_shift (w_shift),
    .i_right (r_mode),
    .o_c     (w_c_rot),
    .o_d     (w_d_rot)
  );

  p_box_56_48 u_pc2 (
    .i_dat (({w_c_rot, w_d_rot})),
    .o_dat (w_pc2)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_mode  <= 1'b0;
    end else if (w_load) begin
      r_c     <= key_i[KEY56_W-1:CD_W];
      r_d     <= key_i[CD_W-1:0];
      r_mode  <= decrypt_i;
      r_cnt   <= '0;
      r_state <= ST_GEN;
    end else if (w_gen && abort_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_fire) begin
      r_c <= w_c_rot;
      r_d <= w_d_rot;
      if (w_last) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign rk_valid_o = w_gen;
  assign rk_o       = w_gen ? w_pc2 : '0;
  assign rk_idx_o   = w_gen ? r_cnt : '0;
  assign rk_last_o  = w_last;
  assign busy_o     = w_gen;
endmodule
